// File: rtl/window_buffer.sv
// 3x3 sliding-window generator for raster-order greyscale pixels: two line
// buffers feed a 3x3 register window, with a single-entry valid/ready output stage.
module window_buffer #(
    parameter int BIT_PER_PIXEL = 8,
    parameter int MAX_WIDTH     = 64,
    parameter int DIM_BITS      = 7
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       start,
    input  logic [DIM_BITS-1:0]        img_width,
    input  logic [DIM_BITS-1:0]        img_height,
    input  logic [BIT_PER_PIXEL-1:0]   pix_in,
    input  logic                       pix_valid,
    output logic                       pix_ready,
    output logic [9*BIT_PER_PIXEL-1:0] win_out,
    output logic                       win_valid,
    input  logic                       win_ready,
    output logic [DIM_BITS-1:0]        win_row,
    output logic [DIM_BITS-1:0]        win_col,
    output logic                       done
);

    localparam int AW = $clog2(MAX_WIDTH);
    localparam logic [DIM_BITS-1:0] ONE   = DIM_BITS'(1);
    localparam logic [DIM_BITS-1:0] TWO   = DIM_BITS'(2);
    localparam logic [DIM_BITS-1:0] THREE = DIM_BITS'(3);
    localparam logic [DIM_BITS-1:0] MAXW  = DIM_BITS'(MAX_WIDTH);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;

    state_t                    state;
    logic [DIM_BITS-1:0]       w_lat, h_lat, row, col, start_w;
    logic [AW-1:0]             lb_addr;
    logic [BIT_PER_PIXEL-1:0]  lb0 [MAX_WIDTH];
    logic [BIT_PER_PIXEL-1:0]  lb1 [MAX_WIDTH];
    logic [BIT_PER_PIXEL-1:0]  win [3][3];
    logic [BIT_PER_PIXEL-1:0]  new_col [3];
    logic [9*BIT_PER_PIXEL-1:0] nxt_win;
    logic                      accept, load, last_col, last_pix;

    assign pix_ready = (state == FILL) && (!win_valid || win_ready);
    assign accept    = pix_valid && pix_ready;
    assign load      = accept && (row >= TWO) && (col >= TWO);
    assign last_col  = (col == w_lat - ONE);
    assign last_pix  = last_col && (row == h_lat - ONE);
    assign lb_addr   = AW'(col);
    assign start_w   = (img_width > MAXW) ? MAXW : img_width;

    // Window as it will look after this accept: old columns 1,2 slide left,
    // right column comes from the pre-update line buffers plus the live pixel.
    always_comb begin
        new_col[0] = lb0[lb_addr];
        new_col[1] = lb1[lb_addr];
        new_col[2] = pix_in;
        nxt_win    = '0;
        for (int unsigned r = 0; r < 3; r++) begin
            nxt_win[(r*3+0)*BIT_PER_PIXEL +: BIT_PER_PIXEL] = win[r][1];
            nxt_win[(r*3+1)*BIT_PER_PIXEL +: BIT_PER_PIXEL] = win[r][2];
            nxt_win[(r*3+2)*BIT_PER_PIXEL +: BIT_PER_PIXEL] = new_col[r];
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            w_lat     <= '0;
            h_lat     <= '0;
            row       <= '0;
            col       <= '0;
            win_out   <= '0;
            win_valid <= 1'b0;
            win_row   <= '0;
            win_col   <= '0;
            done      <= 1'b0;
            for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
                lb0[i] <= '0;
                lb1[i] <= '0;
            end
            for (int unsigned r = 0; r < 3; r++) begin
                for (int unsigned c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else begin
            if (accept) begin
                lb0[lb_addr] <= lb1[lb_addr];
                lb1[lb_addr] <= pix_in;
                for (int unsigned r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                    win[r][2] <= new_col[r];
                end
                if (last_col) begin
                    col <= '0;
                    row <= row + ONE;
                end else begin
                    col <= col + ONE;
                end
            end

            // A fresh window takes priority over clearing on handshake.
            if (load) begin
                win_out   <= nxt_win;
                win_valid <= 1'b1;
                win_row   <= row - ONE;
                win_col   <= col - ONE;
            end else if (win_valid && win_ready) begin
                win_valid <= 1'b0;
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        w_lat <= start_w;
                        h_lat <= img_height;
                        row   <= '0;
                        col   <= '0;
                        if (start_w < THREE || img_height < THREE) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= FILL;
                            done  <= 1'b0;
                        end
                    end
                end
                FILL: begin
                    if (accept && last_pix) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!win_valid || win_ready) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_window_buffer.sv
// Directed testbench for window_buffer: frame streaming, backpressure,
// degenerate sizes, width clamping, mid-frame reset and start-while-busy.
module tb_window_buffer;

    localparam int BPP = 8;
    localparam int MW  = 64;
    localparam int DB  = 7;

    logic            clk = 1'b0;
    logic            n_rst = 1'b0;
    logic            start = 1'b0;
    logic [DB-1:0]   img_width = '0;
    logic [DB-1:0]   img_height = '0;
    logic [BPP-1:0]  pix_in = '0;
    logic            pix_valid = 1'b0;
    logic            pix_ready;
    logic [9*BPP-1:0] win_out;
    logic            win_valid;
    logic            win_ready = 1'b0;
    logic [DB-1:0]   win_row, win_col;
    logic            done;

    int n_cmp = 0;
    int n_bad = 0;

    logic [71:0] got_win[$];
    int          got_row[$];
    int          got_col[$];
    int          acc_cyc[256];
    int          first_valid_cyc, done_cyc, pr_hold, unstable, n_acc;
    logic        pr_at_first, timed_out;
    logic [71:0] first_win;

    always #5 clk = ~clk;

    window_buffer #(.BIT_PER_PIXEL(BPP), .MAX_WIDTH(MW), .DIM_BITS(DB)) dut (
        .clk(clk), .n_rst(n_rst), .start(start),
        .img_width(img_width), .img_height(img_height),
        .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .win_out(win_out), .win_valid(win_valid), .win_ready(win_ready),
        .win_row(win_row), .win_col(win_col), .done(done)
    );

    // Expected window centred at (r,c) for a frame whose pixel k has value base+k.
    function automatic logic [71:0] exp_win(input int r, input int c, input int wc, input int base);
        logic [71:0] v;
        v = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                v[(i*3+j)*8 +: 8] = 8'(base + (r-1+i)*wc + (c-1+j));
        return v;
    endfunction

    task automatic start_frame(input int w, input int h);
        @(negedge clk);
        start = 1'b1;
        img_width = w[DB-1:0];
        img_height = h[DB-1:0];
        pix_valid = 1'b0;
        win_ready = 1'b1;
    endtask

    // Streams npix pixels, records handshaken windows; ends on done, after
    // stop_acc accepts, or when max_cyc expires (timed_out stays 1).
    task automatic run_frame(input int npix, input int base, input int rel_cyc,
                             input int start_cyc, input int stop_acc, input int max_cyc);
        int idx;
        idx = 0;
        got_win.delete(); got_row.delete(); got_col.delete();
        first_valid_cyc = -1; done_cyc = -1; pr_hold = 0; unstable = 0;
        pr_at_first = 1'b1; timed_out = 1'b1;
        for (int cyc = 0; cyc < max_cyc; cyc++) begin
            @(negedge clk);
            start = (cyc == start_cyc);
            if (cyc == start_cyc) begin
                img_width = 7'd3;
                img_height = 7'd3;
            end
            pix_valid = (idx < npix);
            pix_in = 8'(base + idx);
            win_ready = (cyc >= rel_cyc);
            #1;
            if (done) begin
                done_cyc = cyc;
                timed_out = 1'b0;
                break;
            end
            if (win_valid && first_valid_cyc < 0) begin
                first_valid_cyc = cyc;
                first_win = win_out;
                pr_at_first = pix_ready;
            end
            if (win_valid && !win_ready) begin
                if (pix_ready) pr_hold++;
                if (win_out !== first_win) unstable++;
            end
            if (win_valid && win_ready) begin
                got_win.push_back(win_out);
                got_row.push_back(int'(win_row));
                got_col.push_back(int'(win_col));
            end
            if (pix_valid && pix_ready) begin
                acc_cyc[idx] = cyc;
                idx++;
                if (idx == stop_acc) begin
                    timed_out = 1'b0;
                    break;
                end
            end
        end
        n_acc = idx;
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset;
        pix_valid = 1'b1;
        #12;
        n_cmp++; if (pix_ready !== 1'b0) begin n_bad++; $display("FAIL reset_pix_ready got=%b exp=0", pix_ready); end
        n_cmp++; if (win_valid !== 1'b0) begin n_bad++; $display("FAIL reset_win_valid got=%b exp=0", win_valid); end
        n_cmp++; if (win_out !== '0) begin n_bad++; $display("FAIL reset_win_out got=%h exp=0", win_out); end
        n_cmp++; if (win_row !== '0 || win_col !== '0) begin n_bad++; $display("FAIL reset_win_pos got=%0d,%0d exp=0,0", win_row, win_col); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", done); end
        pix_valid = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    task automatic test_basic_4x4;
        start_frame(4, 4);
        run_frame(16, 0, 0, -1, 1000, 200);
        n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL basic_timeout got=%b exp=0", timed_out); end
        n_cmp++; if (got_win.size() != 4) begin n_bad++; $display("FAIL basic_count got=%0d exp=4", got_win.size()); end
        n_cmp++; if (got_win[0] !== 72'h0a_09_08_06_05_04_02_01_00) begin n_bad++; $display("FAIL basic_first_win got=%h exp=0a0908060504020100", got_win[0]); end
        n_cmp++; if (got_row[0] != 1 || got_col[0] != 1) begin n_bad++; $display("FAIL basic_first_pos got=%0d,%0d exp=1,1", got_row[0], got_col[0]); end
        n_cmp++; if (first_valid_cyc != acc_cyc[10] + 1) begin n_bad++; $display("FAIL basic_latency got=%0d exp=%0d", first_valid_cyc, acc_cyc[10] + 1); end
        n_cmp++; if (got_win[3] !== 72'h0f_0e_0d_0b_0a_09_07_06_05) begin n_bad++; $display("FAIL basic_last_win got=%h exp=0f0e0d0b0a09070605", got_win[3]); end
        n_cmp++; if (got_row[3] != 2 || got_col[3] != 2) begin n_bad++; $display("FAIL basic_last_pos got=%0d,%0d exp=2,2", got_row[3], got_col[3]); end
        n_cmp++; if (done_cyc != acc_cyc[15] + 2) begin n_bad++; $display("FAIL basic_done_time got=%0d exp=%0d", done_cyc, acc_cyc[15] + 2); end
    endtask

    task automatic test_backpressure;
        start_frame(4, 4);
        run_frame(16, 0, 40, -1, 1000, 300);
        n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL bp_timeout got=%b exp=0", timed_out); end
        n_cmp++; if (pr_at_first !== 1'b0) begin n_bad++; $display("FAIL bp_pix_ready_drop got=%b exp=0", pr_at_first); end
        n_cmp++; if (pr_hold != 0) begin n_bad++; $display("FAIL bp_pix_ready_hold got=%0d exp=0", pr_hold); end
        n_cmp++; if (unstable != 0) begin n_bad++; $display("FAIL bp_win_stable got=%0d exp=0", unstable); end
        n_cmp++; if (first_win !== 72'h0a_09_08_06_05_04_02_01_00) begin n_bad++; $display("FAIL bp_held_win got=%h exp=0a0908060504020100", first_win); end
        n_cmp++; if (got_win.size() != 4) begin n_bad++; $display("FAIL bp_count got=%0d exp=4", got_win.size()); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (got_win[k] !== exp_win(1 + k/2, 1 + k%2, 4, 0)) begin
                n_bad++;
                $display("FAIL bp_win%0d got=%h exp=%h", k, got_win[k], exp_win(1 + k/2, 1 + k%2, 4, 0));
            end
        end
    endtask

    task automatic test_small;
        int pr_cnt, wv_cnt;
        pr_cnt = 0; wv_cnt = 0;
        start_frame(2, 5);
        @(negedge clk);
        start = 1'b0;
        #1;
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL small_done got=%b exp=1", done); end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            pix_valid = 1'b1;
            win_ready = 1'b1;
            #1;
            if (pix_ready) pr_cnt++;
            if (win_valid) wv_cnt++;
        end
        pix_valid = 1'b0;
        n_cmp++; if (pr_cnt != 0) begin n_bad++; $display("FAIL small_pix_ready got=%0d exp=0", pr_cnt); end
        n_cmp++; if (wv_cnt != 0) begin n_bad++; $display("FAIL small_win_valid got=%0d exp=0", wv_cnt); end
    endtask

    task automatic test_clamp;
        int col_err, win_err;
        col_err = 0; win_err = 0;
        start_frame(100, 3);
        run_frame(192, 0, 0, -1, 1000, 1000);
        n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL clamp_timeout got=%b exp=0", timed_out); end
        n_cmp++; if (got_win.size() != 62) begin n_bad++; $display("FAIL clamp_count got=%0d exp=62", got_win.size()); end
        for (int k = 0; k < 62; k++) begin
            n_cmp++;
            if (got_col[k] != k + 1 || got_row[k] != 1) begin
                n_bad++;
                $display("FAIL clamp_pos%0d got=%0d,%0d exp=1,%0d", k, got_row[k], got_col[k], k + 1);
            end
        end
        n_cmp++; if (got_win[61] !== exp_win(1, 62, 64, 0)) begin n_bad++; $display("FAIL clamp_last_win got=%h exp=%h", got_win[61], exp_win(1, 62, 64, 0)); end
    endtask

    task automatic test_reset_mid;
        start_frame(8, 8);
        run_frame(64, 0, 0, -1, 19, 300);
        @(negedge clk);
        #1;
        n_cmp++; if (win_valid !== 1'b1) begin n_bad++; $display("FAIL rmid_pre_valid got=%b exp=1", win_valid); end
        pix_valid = 1'b1;
        n_rst = 1'b0;
        #1;
        n_cmp++; if (pix_ready !== 1'b0 || win_valid !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL rmid_ctrl got=%b%b%b exp=000", pix_ready, win_valid, done); end
        n_cmp++; if (win_out !== '0 || win_row !== '0 || win_col !== '0) begin n_bad++; $display("FAIL rmid_data got=%h,%0d,%0d exp=0,0,0", win_out, win_row, win_col); end
        pix_valid = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        start_frame(3, 3);
        run_frame(9, 100, 0, -1, 1000, 200);
        n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL rmid_timeout got=%b exp=0", timed_out); end
        n_cmp++; if (got_win.size() != 1) begin n_bad++; $display("FAIL rmid_count got=%0d exp=1", got_win.size()); end
        n_cmp++; if (got_win[0] !== 72'h6c_6b_6a_69_68_67_66_65_64) begin n_bad++; $display("FAIL rmid_win got=%h exp=6c6b6a696867666564", got_win[0]); end
        n_cmp++; if (got_row[0] != 1 || got_col[0] != 1) begin n_bad++; $display("FAIL rmid_pos got=%0d,%0d exp=1,1", got_row[0], got_col[0]); end
    endtask

    task automatic test_start_in_fill;
        start_frame(4, 4);
        run_frame(16, 0, 0, 5, 1000, 200);
        n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL sfill_timeout got=%b exp=0", timed_out); end
        n_cmp++; if (n_acc != 16) begin n_bad++; $display("FAIL sfill_accepts got=%0d exp=16", n_acc); end
        n_cmp++; if (got_win.size() != 4) begin n_bad++; $display("FAIL sfill_count got=%0d exp=4", got_win.size()); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (got_win[k] !== exp_win(1 + k/2, 1 + k%2, 4, 0)) begin
                n_bad++;
                $display("FAIL sfill_win%0d got=%h exp=%h", k, got_win[k], exp_win(1 + k/2, 1 + k%2, 4, 0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_4x4();
        test_backpressure();
        test_small();
        test_clamp();
        test_reset_mid();
        test_start_in_fill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
